// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver with an integrated first-word-fall-through receive FIFO.
// Frame format (data width, parity, stop bits) and bit period are set by
// parameters. Received words are buffered and framing, parity and overrun
// problems are reported through sticky flags.
//
// Ports:
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_rx          asynchronous serial input, idles high
//   o_data        FIFO head word (valid while o_valid is high)
//   o_valid       FIFO non-empty
//   i_ready       consumer pop; a pop occurs when o_valid && i_ready
//   o_count       FIFO occupancy (0..DEPTH)
//   o_frame_err   sticky: a stop bit was sampled low
//   o_parity_err  sticky: a parity mismatch occurred
//   o_overrun     sticky: a word was dropped because the FIFO was full
//   i_err_clear   one-cycle pulse clearing all three sticky flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rx,
  output logic [DATA_BITS-1:0]     o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_frame_err,
  output logic                     o_parity_err,
  output logic                     o_overrun,
  input  logic                     i_err_clear
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Synchroniser
  logic rx_meta_q;
  logic rx_s_q;

  // Receiver FSM state
  state_t                 state_q,    state_d;
  logic [TW-1:0]          timer_q,    timer_d;
  logic [IW-1:0]          bit_idx_q,  bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic                   par_err_q,  par_err_d;

  // Frame outcome strobes from the FSM
  logic push_req_s;
  logic set_fe_s;
  logic set_pe_s;
  logic par_calc_s;

  // FIFO state
  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q,  count_d;
  logic                   valid_q,  valid_d;
  logic [DATA_BITS-1:0]   data_q,   data_d;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   set_ov_s;

  // Sticky flags
  logic fe_q, fe_d;
  logic pe_q, pe_d;
  logic ov_q, ov_d;

  // Receiver next-state logic: frame decoding driven by the synchronised line.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    push_req_s = 1'b0;
    set_fe_s   = 1'b0;
    set_pe_s   = 1'b0;
    // Even parity passes when data and parity bit XOR to 0; odd when to 1.
    par_calc_s = (^shift_q) ^ rx_s_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d   = '0;
          bit_idx_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            // Line went back high before mid start bit: treat as noise.
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end

      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == IDX_LAST) begin
            stop_idx_d = 1'b0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_PARITY: begin
        if (timer_q == T_FULL) begin
          timer_d    = '0;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
          if (PARITY == 2) begin
            par_err_d = ~par_calc_s;
          end else begin
            par_err_d = par_calc_s;
          end
        end else begin
          state_d = S_PARITY;
        end
      end

      S_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (!rx_s_q) begin
            set_fe_s = 1'b1;
            state_d  = S_BREAK;
          end else if (stop_idx_q == STOP_LAST) begin
            // Returning to IDLE at mid stop bit lets a back-to-back start
            // edge be caught without losing any time.
            state_d = S_IDLE;
            if (par_err_q) begin
              set_pe_s = 1'b1;
            end else begin
              push_req_s = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end

      S_BREAK: begin
        // A line held low must not be decoded as a stream of frames.
        timer_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO next-state logic: push/pop arbitration, pointers, occupancy and head.
  always_comb begin
    pop_s    = valid_q && i_ready;
    full_s   = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_s   = push_req_s && (!full_s || pop_s);
    set_ov_s = push_req_s && full_s && !pop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);

    // Head register: bypass the incoming word when it lands at the new head.
    data_d = data_q;
    if (count_d != '0) begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
        data_d = shift_q;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end else begin
      data_d = data_q;
    end
  end

  // Sticky flag next-state: a set event in the clearing cycle wins.
  always_comb begin
    fe_d = set_fe_s | (fe_q & ~i_err_clear);
    pe_d = set_pe_s | (pe_q & ~i_err_clear);
    ov_d = set_ov_s | (ov_q & ~i_err_clear);
  end

  // State registers for synchroniser, receiver, FIFO control and flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ov_q       <= ov_d;
    end
  end

  // FIFO storage: only accepted pushes write; stale entries are never
  // visible because the head register is only loaded from occupied slots.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_count      = count_q;
  assign o_frame_err  = fe_q;
  assign o_parity_err = pe_q;
  assign o_overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. Four instances with different frame
// formats are exercised one after another; a queue-based reference model of
// the receive FIFO and sticky flags provides every expected value.
//   inst 0: defaults (250 clk/bit, 8N1, depth 16)
//   inst 1: 16 clk/bit, 8 data, even parity, 1 stop, depth 16
//   inst 2: 16 clk/bit, 8N1, depth 4
//   inst 3: 8 clk/bit, 7 data, odd parity, 2 stop, depth 4
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst, rx, rdy, clr;
  logic [3:0] vld, fe, pe, ov;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [4:0] c0, c1;
  logic [2:0] c2, c3;

  uart_rx_fifo u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_rx(rx[0]), .o_data(d0), .o_valid(vld[0]),
    .i_ready(rdy[0]), .o_count(c0), .o_frame_err(fe[0]), .o_parity_err(pe[0]),
    .o_overrun(ov[0]), .i_err_clear(clr[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_rx(rx[1]), .o_data(d1), .o_valid(vld[1]),
    .i_ready(rdy[1]), .o_count(c1), .o_frame_err(fe[1]), .o_parity_err(pe[1]),
    .o_overrun(ov[1]), .i_err_clear(clr[1]));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_rx(rx[2]), .o_data(d2), .o_valid(vld[2]),
    .i_ready(rdy[2]), .o_count(c2), .o_frame_err(fe[2]), .o_parity_err(pe[2]),
    .o_overrun(ov[2]), .i_err_clear(clr[2]));

  uart_rx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst[3]), .i_rx(rx[3]), .o_data(d3), .o_valid(vld[3]),
    .i_ready(rdy[3]), .o_count(c3), .o_frame_err(fe[3]), .o_parity_err(pe[3]),
    .o_overrun(ov[3]), .i_err_clear(clr[3]));

  int n_checks;
  int n_pass;

  // Reference model: words the receiver should hold, and the sticky flags.
  int unsigned mq[$];
  logic m_fe, m_pe, m_ov;

  function automatic int cpb_of(int k);
    case (k)
      0: return 250;
      1: return 16;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int nb_of(int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(int k);
    case (k)
      1: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int depth_of(int k);
    return (k >= 2) ? 4 : 16;
  endfunction

  function automatic logic [31:0] obs_data(int k);
    case (k)
      0: return 32'(d0);
      1: return 32'(d1);
      2: return 32'(d2);
      default: return 32'(d3);
    endcase
  endfunction

  function automatic logic [31:0] obs_cnt(int k);
    case (k)
      0: return 32'(c0);
      1: return 32'(c1);
      2: return 32'(c2);
      default: return 32'(c3);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic check_state(input int k, input string tag);
    check_eq({tag, ".count"}, obs_cnt(k), mq.size());
    check_eq({tag, ".valid"}, 32'(vld[k]), 32'(mq.size() != 0));
    if (mq.size() != 0) check_eq({tag, ".data"}, obs_data(k), mq[0]);
    check_eq({tag, ".frame_err"}, 32'(fe[k]), 32'(m_fe));
    check_eq({tag, ".parity_err"}, 32'(pe[k]), 32'(m_pe));
    check_eq({tag, ".overrun"}, 32'(ov[k]), 32'(m_ov));
  endtask

  task automatic reset_dut(input int k);
    rst[k] = 1'b1;
    rx[k]  = 1'b1;
    rdy[k] = 1'b0;
    clr[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst[k] = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int cycles);
    rx[k] = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clear_pulse(input int k);
    clr[k] = 1'b1;
    @(negedge clk);
    clr[k] = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_ov = 1'b0;
  endtask

  // Pop cnt times (also when empty, where the pop must be ignored).
  task automatic pop_check(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (mq.size() != 0) check_eq("pop.data", obs_data(k), mq[0]);
      rdy[k] = 1'b1;
      @(negedge clk);
      rdy[k] = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      check_eq("pop.count", obs_cnt(k), mq.size());
    end
  endtask

  // Drive one frame starting at a negedge. sel[0]/sel[1] pulse i_ready /
  // i_err_clear on the clock edge of the final stop sample. abort_at >= 0
  // asserts reset at that cycle of the frame instead of finishing it.
  task automatic send_frame(input int k, input logic [8:0] data, input bit par_bad,
                            input bit stop_bad, input logic [1:0] sel,
                            input bit lat_chk, input int abort_at);
    int cpb, nb, pm, ns, n, p, e;
    logic [15:0] bits;
    logic pbit;
    cpb = cpb_of(k);
    nb  = nb_of(k);
    pm  = par_of(k);
    ns  = stop_of(k);
    n   = nb + ((pm != 0) ? 1 : 0) + ns;
    bits = 16'hFFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1 + i] = data[i];
    if (pm != 0) begin
      pbit = (pm == 1) ? ($countones(data) % 2 == 1) : ($countones(data) % 2 == 0);
      bits[1 + nb] = pbit ^ par_bad;
    end
    for (int s = 0; s < ns; s++) bits[1 + nb + ((pm != 0) ? 1 : 0) + s] = ~stop_bad;
    // Edge of the final stop sample: 2 synchroniser cycles, 1 to leave
    // IDLE, half a bit to mid start, then n full bits.
    p = 3 + cpb / 2 + n * cpb;
    for (int c = 0; c < (n + 1) * cpb; c++) begin
      if (c == abort_at) begin
        rx[k]  = 1'b1;
        rst[k] = 1'b1;
        @(negedge clk);
        rst[k] = 1'b0;
        model_reset();
        return;
      end
      rx[k] = bits[c / cpb];
      if (lat_chk && c == p - 1) check_eq("latency.before", 32'(vld[k]), 32'd0);
      if (lat_chk && c == p) check_eq("latency.after", 32'(vld[k]), 32'd1);
      if (c == p - 1) begin
        if (sel[0] && mq.size() != 0) check_eq("push_pop.head", obs_data(k), mq[0]);
        rdy[k] = sel[0];
        clr[k] = sel[1];
      end
      if (c == p) begin
        rdy[k] = 1'b0;
        clr[k] = 1'b0;
      end
      @(negedge clk);
    end
    // Model: the frame's outcome lands at edge e; the strobes at edge p.
    e = stop_bad ? p - (ns - 1) * cpb : p;
    if (sel[0] && mq.size() != 0) void'(mq.pop_front());
    if (sel[1] && e == p) begin
      m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    end
    if (stop_bad) m_fe = 1'b1;
    else if (par_bad) m_pe = 1'b1;
    else if (mq.size() >= depth_of(k)) m_ov = 1'b1;
    else mq.push_back(32'(data));
    if (sel[1] && e != p) begin
      m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    end
  endtask

  task automatic rand_frames(input int k, input int nfr);
    logic [8:0] data;
    logic [1:0] sel;
    bit pb, sb;
    int cpb;
    cpb = cpb_of(k);
    for (int i = 0; i < nfr; i++) begin
      data = 9'($urandom) & 9'((1 << nb_of(k)) - 1);
      pb   = (par_of(k) != 0) && ($urandom_range(0, 4) == 0);
      sb   = ($urandom_range(0, 6) == 0);
      sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(k, data, pb, sb, sel, 1'b0, -1);
      check_state(k, "rnd");
      if (sb || $urandom_range(0, 3) == 0) idle(k, $urandom_range(cpb, 3 * cpb));
      if ($urandom_range(0, 2) == 0) begin
        pop_check(k, $urandom_range(1, 3));
        check_state(k, "rnd.pop");
      end
      if ($urandom_range(0, 9) == 0) begin
        clear_pulse(k);
        check_state(k, "rnd.clear");
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 4'b0000;
    rx  = 4'b1111;
    rdy = 4'b0000;
    clr = 4'b0000;
    model_reset();
    @(negedge clk);

    // ---------------- instance 0: defaults, 8N1 at 250 clk/bit ----------
    reset_dut(0);
    check_state(0, "k0.reset");
    check_eq("k0.reset.data", obs_data(0), 32'h0);
    send_frame(0, 9'h42, 1'b0, 1'b0, 2'b00, 1'b1, -1);
    check_state(0, "k0.8n1");
    pop_check(0, 1);
    check_state(0, "k0.popped");
    // Short low glitch: well under half a bit.
    rx[0] = 1'b0;
    repeat (10) @(negedge clk);
    idle(0, 2 * 250);
    check_state(0, "k0.glitch");
    // Framing error then a long break.
    send_frame(0, 9'hA5, 1'b0, 1'b1, 2'b00, 1'b0, -1);
    rx[0] = 1'b0;
    repeat (20 * 250) @(negedge clk);
    check_state(0, "k0.break");
    idle(0, 250);
    send_frame(0, 9'h5A, 1'b0, 1'b0, 2'b00, 1'b0, -1);
    check_state(0, "k0.after_break");
    // Reset during data bit 3 of 0xFF.
    send_frame(0, 9'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 4 * 250 + 125);
    check_state(0, "k0.midreset");
    check_eq("k0.midreset.data", obs_data(0), 32'h0);
    idle(0, 250);
    send_frame(0, 9'h3C, 1'b0, 1'b0, 2'b00, 1'b0, -1);
    check_state(0, "k0.after_reset");

    // ---------------- instance 1: even parity ----------------------------
    reset_dut(1);
    send_frame(1, 9'h42, 1'b1, 1'b0, 2'b00, 1'b0, -1);
    check_state(1, "k1.bad_parity");
    send_frame(1, 9'h43, 1'b0, 1'b0, 2'b00, 1'b0, -1);
    check_state(1, "k1.good_parity");
    clear_pulse(1);
    check_state(1, "k1.cleared");
    pop_check(1, 1);
    rand_frames(1, 20);

    // ---------------- instance 2: overrun, depth 4 -----------------------
    reset_dut(2);
    for (int v = 1; v <= 5; v++) send_frame(2, 9'(v), 1'b0, 1'b0, 2'b00, 1'b0, -1);
    check_state(2, "k2.overrun");
    pop_check(2, 4);
    pop_check(2, 1);
    check_state(2, "k2.empty_pop");
    clear_pulse(2);
    check_state(2, "k2.cleared");
    for (int v = 17; v <= 20; v++) send_frame(2, 9'(v), 1'b0, 1'b0, 2'b00, 1'b0, -1);
    check_state(2, "k2.full");
    send_frame(2, 9'h15, 1'b0, 1'b0, 2'b01, 1'b0, -1);
    check_state(2, "k2.push_pop_full");
    pop_check(2, 4);
    check_state(2, "k2.drained");

    // ---------------- instance 3: 7 data, odd parity, 2 stop -------------
    reset_dut(3);
    check_state(3, "k3.reset");
    rand_frames(3, 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an integrated receive FIFO, the successor to the fixed 8N1 receive path on the core's serial port.
- Supports configurable data width, parity mode, stop-bit count and baud divisor.
- Buffers received words in a first-word-fall-through FIFO and exposes sticky framing, parity and overrun flags.
- Sits between the board RX pin and the core's MMIO/UART read path.

Parameters:
- CLKS_PER_BIT, 250, i_clk cycles per UART bit; must be ≥ 4.
- DATA_BITS, 8, data bits per frame; 5–9 allowed.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- DEPTH, 16, FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_rx  in  1  asynchronous serial input; idles high.
- o_data  out  DATA_BITS  FIFO head word.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer pop; a pop occurs when o_valid && i_ready.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_frame_err  out  1  sticky: a stop bit was sampled as 0.
- o_parity_err  out  1  sticky: a parity mismatch occurred.
- o_overrun  out  1  sticky: a word was dropped because the FIFO was full.
- i_err_clear  in  1  one-cycle pulse; clears all three sticky flags.

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_valid=0, o_count=0, o_data=0, all error flags 0.
  - FSM goes to IDLE, both synchroniser flops go to 1, FIFO pointers go to 0.
  - Reset asserted mid-frame abandons the frame; no partial word is pushed.
- Synchroniser: 2-flop on i_rx; rx_s lags i_rx by 2 cycles. All FSM decisions use rx_s.
- Bit timer: counts 0..CLKS_PER_BIT-1. It is reloaded to 0 on every state entry.
- IDLE:
  - rx_s==0 → START, timer cleared.
- START:
  - At timer==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - Sample 0 → DATA, bit index 0, timer restarted.
  - Sample 1 → glitch; return to IDLE with no flag set.
- DATA:
  - Each time timer==CLKS_PER_BIT-1, sample rx_s into shift register bit [index], LSB first.
  - After bit DATA_BITS-1 → PARITY if PARITY≠0, else STOP.
- PARITY:
  - Sample one bit.
  - Error if XOR(data)^bit ≠ 0 (even mode) or ≠ 1 (odd mode).
  - The result is latched as pending; → STOP.
- STOP:
  - Sample STOP_BITS stop bits, each at a full-bit interval.
  - Any sample of 0 → set o_frame_err and discard the word (no push), → BREAK.
  - All samples 1 → on the cycle of the final stop sample, push the word if parity is OK. On parity error, set o_parity_err and discard the word. → IDLE.
- BREAK: wait until rx_s==1, then → IDLE. This prevents a held-low line from being decoded as repeated frames.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge is detected with no gap.
- Latency: o_valid rises the cycle after the final stop-bit sample.
- FIFO:
  - First-word-fall-through: o_data = mem[rd_ptr] whenever o_valid=1.
  - o_data is undefined-but-stable when empty; it is 0 after reset.
  - Push when full with no pop → word dropped, o_overrun set.
  - Push and pop in the same cycle: both succeed, o_count unchanged. This holds even when full.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH; o_count saturates logically at DEPTH.
- Sticky flags:
  - Set on their event; cleared by i_err_clear.
  - If a set event and i_err_clear occur in the same cycle, set wins.
  - Errors never block the FIFO or the FSM.

Test Plan:
- 8N1 defaults: send 0x42 LSB first (bits 0,1,0,0,0,0,1,0, stop 1) at 250 clk/bit → o_valid=1 with o_data=0x42, o_count=1. Then pulse i_ready for one cycle → o_valid=0, o_count=0.
- PARITY=1: send 0x42 with parity bit 1 (correct is 0) → no push, o_parity_err=1. Then send 0x43 with parity 1 → o_data=0x43, o_parity_err stays 1 until i_err_clear.
- Frame error: send 0xA5 with the stop bit driven 0, then hold the line low for 20 bit times → o_frame_err=1, o_count=0, no further words received. Release the line high and send 0x5A → o_data=0x5A.
- Overrun with DEPTH=4, i_ready=0: send 0x01..0x05 → o_count=4, o_overrun=1. Popping returns 0x01, 0x02, 0x03, 0x04 in order.
- Glitch: drive i_rx low for 10 cycles (well under half a bit) → FSM returns to IDLE, no push, no flag set.
- Reset mid-frame: assert i_rst during data bit 3 of 0xFF → all outputs reset. Then send 0x3C → o_data=0x3C, o_count=1, flags all 0.
